// File: rtl/compositor_pkg.sv
// compositor_pkg: shared types and constants for the layer compositor.
//   pixel_t      : {alpha, rgb} word as returned by a sprite ROM at default width
//   ALPHA_OPAQUE : the only alpha code treated as opaque
//   *_DEF        : default widths/counts used as parameter defaults
package compositor_pkg;

    localparam int NUM_LAYERS_DEF  = 4;
    localparam int COLOR_W_DEF     = 12;
    localparam int X_W_DEF         = 10;
    localparam int Y_W_DEF         = 9;
    localparam int ADDR_W_DEF      = 12;
    localparam int ANIM_FRAMES_DEF = 3;
    localparam int ANIM_PERIOD_DEF = 8;

    localparam logic [3:0] ALPHA_OPAQUE = 4'hF;

    typedef struct packed {
        logic [3:0]             alpha;
        logic [COLOR_W_DEF-1:0] rgb;
    } pixel_t;

endpackage

// File: rtl/layer_hit.sv
// layer_hit: one sprite layer's frame-synchronous shadow geometry, hit test
// and ROM address generation. Outputs are registered (pipeline stage S1).
//   vga_clk, clrn          : pixel clock, asynchronous active-low reset
//   frame_start            : loads en/x/y/w/h into the shadow registers
//   en_in, x_in, y_in,
//   w_in, h_in             : live layer geometry (sampled only on frame_start)
//   row_addr, col_addr     : current pixel coordinate
//   hit                    : coordinate lies inside the enabled layer (S1)
//   addr                   : (row-y)*w + (col-x) on a hit, else 0 (S1)
module layer_hit #(
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int ADDR_W = 12
) (
    input  logic              vga_clk,
    input  logic              clrn,
    input  logic              frame_start,
    input  logic              en_in,
    input  logic [X_W-1:0]    x_in,
    input  logic [Y_W-1:0]    y_in,
    input  logic [X_W-1:0]    w_in,
    input  logic [Y_W-1:0]    h_in,
    input  logic [Y_W-1:0]    row_addr,
    input  logic [X_W-1:0]    col_addr,
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);

    logic              en_q, en_d;
    logic [X_W-1:0]    x_q, x_d, w_q, w_d;
    logic [Y_W-1:0]    y_q, y_d, h_q, h_d;
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [X_W:0]   col_ext, x_ext, x_end;
    logic [Y_W:0]   row_ext, y_ext, y_end;
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;

    always_comb begin
        en_d = en_q;
        x_d  = x_q;
        y_d  = y_q;
        w_d  = w_q;
        h_d  = h_q;
        if (frame_start) begin
            en_d = en_in;
            x_d  = x_in;
            y_d  = y_in;
            w_d  = w_in;
            h_d  = h_in;
        end

        // One extra bit so x+w / y+h cannot wrap; w==0 or h==0 gives an
        // empty interval and therefore never hits.
        col_ext = (X_W+1)'(col_addr);
        x_ext   = (X_W+1)'(x_q);
        x_end   = x_ext + (X_W+1)'(w_q);
        row_ext = (Y_W+1)'(row_addr);
        y_ext   = (Y_W+1)'(y_q);
        y_end   = y_ext + (Y_W+1)'(h_q);

        hit_d = en_q && (col_ext >= x_ext) && (col_ext < x_end)
                     && (row_ext >= y_ext) && (row_ext < y_end);

        // Modular arithmetic at ADDR_W bits yields the truncated address
        // directly, regardless of how ADDR_W compares to X_W/Y_W.
        dx     = col_addr - x_q;
        dy     = row_addr - y_q;
        addr_d = hit_d ? (ADDR_W'(dy) * ADDR_W'(w_q) + ADDR_W'(dx)) : '0;
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            en_q   <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            w_q    <= '0;
            h_q    <= '0;
            hit_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            en_q   <= en_d;
            x_q    <= x_d;
            y_q    <= y_d;
            w_q    <= w_d;
            h_q    <= h_d;
            hit_q  <= hit_d;
            addr_q <= addr_d;
        end
    end

    assign hit  = hit_q;
    assign addr = addr_q;

endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: NUM_LAYERS sprite layers over a background colour.
// S1: per-layer hit test + ROM address (layer_hit instances).
// S2: opacity/priority resolve (layer 0 highest) into rgb_out/hit_mask.
// Also sequences sprite animation cels and flags layer-0 collisions.
//   vga_clk, clrn              : pixel clock, asynchronous active-low reset
//   pix_valid, row_addr,
//   col_addr                   : pixel coordinate from the VGA timing block
//   frame_start                : per-frame pulse (shadow load, animation, collision)
//   anim_hold                  : freeze animation counters
//   layer_en/x/y/w/h           : live layer geometry, packed per layer
//   lyr_addr / lyr_data        : ROM address out (S1) / {alpha,rgb} back in S1
//   bg_rgb                     : background colour, presented in S1
//   anim_cel                   : current animation cel
//   rgb_out, rgb_valid,
//   hit_mask                   : composited output (S2)
//   collision                  : layer 0 overlapped another opaque layer last frame
// Build option: define LAYER_COMPOSITOR_COLLISION_EN to implement the
// collision accumulator; otherwise collision is tied to 0.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS  = NUM_LAYERS_DEF,
    parameter int COLOR_W     = COLOR_W_DEF,
    parameter int X_W         = X_W_DEF,
    parameter int Y_W         = Y_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int ANIM_FRAMES = ANIM_FRAMES_DEF,
    parameter int ANIM_PERIOD = ANIM_PERIOD_DEF,
    localparam int CEL_W      = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1,
    localparam int CNT_W      = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1,
    localparam int PIX_W      = 4 + COLOR_W
) (
    input  logic                         vga_clk,
    input  logic                         clrn,
    input  logic                         pix_valid,
    input  logic [Y_W-1:0]               row_addr,
    input  logic [X_W-1:0]               col_addr,
    input  logic                         frame_start,
    input  logic                         anim_hold,
    input  logic [NUM_LAYERS-1:0]        layer_en,
    input  logic [NUM_LAYERS*X_W-1:0]    layer_x,
    input  logic [NUM_LAYERS*X_W-1:0]    layer_w,
    input  logic [NUM_LAYERS*Y_W-1:0]    layer_y,
    input  logic [NUM_LAYERS*Y_W-1:0]    layer_h,
    output logic [NUM_LAYERS*ADDR_W-1:0] lyr_addr,
    input  logic [NUM_LAYERS*PIX_W-1:0]  lyr_data,
    input  logic [COLOR_W-1:0]           bg_rgb,
    output logic [CEL_W-1:0]             anim_cel,
    output logic [COLOR_W-1:0]           rgb_out,
    output logic                         rgb_valid,
    output logic [NUM_LAYERS-1:0]        hit_mask,
    output logic                         collision
);

    logic [NUM_LAYERS-1:0] s1_hit;
    logic [NUM_LAYERS-1:0] opaque;
    logic [COLOR_W-1:0]    lyr_rgb [NUM_LAYERS];
    logic [COLOR_W-1:0]    rgb_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
            layer_hit #(
                .X_W    (X_W),
                .Y_W    (Y_W),
                .ADDR_W (ADDR_W)
            ) u_layer_hit (
                .vga_clk     (vga_clk),
                .clrn        (clrn),
                .frame_start (frame_start),
                .en_in       (layer_en[gi]),
                .x_in        (layer_x[gi*X_W +: X_W]),
                .y_in        (layer_y[gi*Y_W +: Y_W]),
                .w_in        (layer_w[gi*X_W +: X_W]),
                .h_in        (layer_h[gi*Y_W +: Y_W]),
                .row_addr    (row_addr),
                .col_addr    (col_addr),
                .hit         (s1_hit[gi]),
                .addr        (lyr_addr[gi*ADDR_W +: ADDR_W])
            );
            assign opaque[gi]  = s1_hit[gi] &&
                                 (lyr_data[gi*PIX_W+COLOR_W +: 4] == ALPHA_OPAQUE);
            assign lyr_rgb[gi] = lyr_data[gi*PIX_W +: COLOR_W];
        end
    endgenerate

    // Scan from lowest priority upward so the lowest-index opaque layer wins.
    always_comb begin
        rgb_sel = bg_rgb;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) rgb_sel = lyr_rgb[i];
        end
    end

    // ---------------- S1 valid and S2 output registers ----------------
    logic                  s1_valid_q, s1_valid_d;
    logic                  rgb_valid_q, rgb_valid_d;
    logic [COLOR_W-1:0]    rgb_out_q, rgb_out_d;
    logic [NUM_LAYERS-1:0] hit_mask_q, hit_mask_d;

    always_comb begin
        s1_valid_d  = pix_valid;
        rgb_valid_d = s1_valid_q;
        rgb_out_d   = s1_valid_q ? rgb_sel : '0;
        hit_mask_d  = s1_valid_q ? opaque  : '0;
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            s1_valid_q  <= 1'b0;
            rgb_valid_q <= 1'b0;
            rgb_out_q   <= '0;
            hit_mask_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            rgb_valid_q <= rgb_valid_d;
            rgb_out_q   <= rgb_out_d;
            hit_mask_q  <= hit_mask_d;
        end
    end

    assign rgb_out   = rgb_out_q;
    assign rgb_valid = rgb_valid_q;
    assign hit_mask  = hit_mask_q;

    // ---------------- Animation ----------------
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CEL_W-1:0] anim_cel_q, anim_cel_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        anim_cel_d  = anim_cel_q;
        if (frame_start && !anim_hold) begin
            if (frame_cnt_q == CNT_W'(ANIM_PERIOD - 1)) begin
                frame_cnt_d = '0;
                anim_cel_d  = (anim_cel_q == CEL_W'(ANIM_FRAMES - 1)) ? '0
                                                                      : anim_cel_q + CEL_W'(1);
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            frame_cnt_q <= '0;
            anim_cel_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            anim_cel_q  <= anim_cel_d;
        end
    end

    assign anim_cel = anim_cel_q;

    // ---------------- Collision ----------------
`ifdef LAYER_COMPOSITOR_COLLISION_EN
    logic coll_hit;
    logic coll_acc_q, coll_acc_d;
    logic collision_q, collision_d;

    // Layer 0 opaque together with any other opaque layer on an S2 pixel.
    assign coll_hit = hit_mask_q[0] && (|(hit_mask_q >> 1));

    always_comb begin
        coll_acc_d  = coll_acc_q | coll_hit;
        collision_d = collision_q;
        if (frame_start) begin
            collision_d = coll_acc_q;
            coll_acc_d  = coll_hit;   // a hit on the boundary cycle belongs to the new frame
        end
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            coll_acc_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            coll_acc_q  <= coll_acc_d;
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor with two layers, ANIM_PERIOD=2,
// ANIM_FRAMES=3. Layer 0: (300,100) 34x24. Layer 1: (320,105) 20x10.
module tb_layer_compositor;

    localparam int NL = 2;

    logic          vga_clk = 1'b0;
    logic          clrn;
    logic          pix_valid;
    logic [8:0]    row_addr;
    logic [9:0]    col_addr;
    logic          frame_start;
    logic          anim_hold;
    logic [NL-1:0] layer_en;
    logic [19:0]   layer_x, layer_w;
    logic [17:0]   layer_y, layer_h;
    logic [23:0]   lyr_addr;
    logic [31:0]   lyr_data;
    logic [11:0]   bg_rgb;
    logic [1:0]    anim_cel;
    logic [11:0]   rgb_out;
    logic          rgb_valid;
    logic [NL-1:0] hit_mask;
    logic          collision;

    int n_vec = 0;
    int n_err = 0;

`ifdef LAYER_COMPOSITOR_COLLISION_EN
    localparam logic COLL_EXP = 1'b1;
`else
    localparam logic COLL_EXP = 1'b0;
`endif

    layer_compositor #(
        .NUM_LAYERS  (NL),
        .ANIM_FRAMES (3),
        .ANIM_PERIOD (2)
    ) dut (
        .vga_clk     (vga_clk),
        .clrn        (clrn),
        .pix_valid   (pix_valid),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .frame_start (frame_start),
        .anim_hold   (anim_hold),
        .layer_en    (layer_en),
        .layer_x     (layer_x),
        .layer_w     (layer_w),
        .layer_y     (layer_y),
        .layer_h     (layer_h),
        .lyr_addr    (lyr_addr),
        .lyr_data    (lyr_data),
        .bg_rgb      (bg_rgb),
        .anim_cel    (anim_cel),
        .rgb_out     (rgb_out),
        .rgb_valid   (rgb_valid),
        .hit_mask    (hit_mask),
        .collision   (collision)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic        pv;
        logic [8:0]  row;
        logic [9:0]  col;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [11:0] bg;
        logic [11:0] a0;
        logic [11:0] a1;
        logic [11:0] rgb;
        logic [1:0]  mask;
        logic        vld;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // One pixel through the pipe; checks the composited hit mask.
    task automatic run_pix(input string nm, input logic [8:0] r, input logic [9:0] c,
                           input logic [1:0] exp_mask);
        pix_valid = 1'b1;
        row_addr  = r;
        col_addr  = c;
        tick();
        pix_valid = 1'b0;
        tick();
        chk(nm, 32'(hit_mask), 32'(exp_mask));
    endtask

    task automatic set_default_layers();
        layer_en = 2'b11;
        layer_x  = {10'd320, 10'd300};
        layer_w  = {10'd20,  10'd34};
        layer_y  = {9'd105,  9'd100};
        layer_h  = {9'd10,   9'd24};
    endtask

    initial begin
        //            pv  row  col  d0        d1        bg       a0   a1   rgb      mask   vld
        vecs[0]  = '{1'b1, 110, 310, 16'hFABC, 16'hF222, 12'h333, 350, 0,   12'hABC, 2'b01, 1'b1};
        vecs[1]  = '{1'b1, 108, 325, 16'h0111, 16'hF222, 12'h333, 297, 65,  12'h222, 2'b10, 1'b1};
        vecs[2]  = '{1'b1, 108, 325, 16'h0111, 16'hE222, 12'h333, 297, 65,  12'h333, 2'b00, 1'b1};
        vecs[3]  = '{1'b1, 108, 325, 16'hF111, 16'hF222, 12'h333, 297, 65,  12'h111, 2'b11, 1'b1};
        vecs[4]  = '{1'b1, 123, 333, 16'hFABC, 16'hF222, 12'h333, 815, 0,   12'hABC, 2'b01, 1'b1};
        vecs[5]  = '{1'b1, 110, 334, 16'hFABC, 16'hF222, 12'h333, 0,   114, 12'h222, 2'b10, 1'b1};
        vecs[6]  = '{1'b1, 100, 299, 16'hFABC, 16'hF222, 12'h333, 0,   0,   12'h333, 2'b00, 1'b1};
        vecs[7]  = '{1'b1, 99,  300, 16'hFABC, 16'hF222, 12'h333, 0,   0,   12'h333, 2'b00, 1'b1};
        vecs[8]  = '{1'b1, 100, 300, 16'hFABC, 16'hF222, 12'h333, 0,   0,   12'hABC, 2'b01, 1'b1};
        vecs[9]  = '{1'b0, 0,   0,   16'hFABC, 16'hF222, 12'h333, 0,   0,   12'h000, 2'b00, 1'b0};
        vecs[10] = '{1'b1, 114, 339, 16'hFABC, 16'hF222, 12'h333, 0,   199, 12'h222, 2'b10, 1'b1};
        vecs[11] = '{1'b1, 115, 339, 16'hFABC, 16'hF222, 12'h333, 0,   0,   12'h333, 2'b00, 1'b1};

        clrn        = 1'b0;
        pix_valid   = 1'b0;
        row_addr    = '0;
        col_addr    = '0;
        frame_start = 1'b0;
        anim_hold   = 1'b0;
        layer_en    = '0;
        layer_x     = '0;
        layer_w     = '0;
        layer_y     = '0;
        layer_h     = '0;
        lyr_data    = '0;
        bg_rgb      = '0;

        // ---- reset state ----
        repeat (3) @(negedge vga_clk);
        chk("rst_rgb_out",   32'(rgb_out),   0);
        chk("rst_rgb_valid", 32'(rgb_valid), 0);
        chk("rst_hit_mask",  32'(hit_mask),  0);
        chk("rst_lyr_addr",  32'(lyr_addr),  0);
        chk("rst_anim_cel",  32'(anim_cel),  0);
        chk("rst_collision", 32'(collision), 0);
        clrn = 1'b1;
        tick();

        set_default_layers();
        pulse_frame();

        // ---- table-driven vectors ----
        for (int i = 0; i < 12; i++) begin
            pix_valid = vecs[i].pv;
            row_addr  = vecs[i].row;
            col_addr  = vecs[i].col;
            lyr_data  = {vecs[i].d1, vecs[i].d0};
            bg_rgb    = vecs[i].bg;
            tick();
            chk($sformatf("v%0d_addr0", i), 32'(lyr_addr[11:0]),  32'(vecs[i].a0));
            chk($sformatf("v%0d_addr1", i), 32'(lyr_addr[23:12]), 32'(vecs[i].a1));
            pix_valid = 1'b0;
            tick();
            chk($sformatf("v%0d_rgb", i),   32'(rgb_out),   32'(vecs[i].rgb));
            chk($sformatf("v%0d_mask", i),  32'(hit_mask),  32'(vecs[i].mask));
            chk($sformatf("v%0d_valid", i), 32'(rgb_valid), 32'(vecs[i].vld));
        end

        lyr_data = {16'hF222, 16'hFABC};
        bg_rgb   = 12'h333;

        // ---- shadow timing ----
        layer_x = {10'd320, 10'd400};
        run_pix("shadow_old", 110, 310, 2'b01);
        pix_valid   = 1'b1;
        row_addr    = 110;
        col_addr    = 310;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        tick();
        chk("shadow_same_cycle", 32'(hit_mask), 32'(2'b01));
        run_pix("shadow_new_miss", 110, 310, 2'b00);
        run_pix("shadow_new_hit",  110, 400, 2'b01);

        layer_x = {10'd320, 10'd300};
        layer_w = {10'd20, 10'd0};
        pulse_frame();
        run_pix("w0_a", 110, 310, 2'b00);
        run_pix("w0_b", 100, 300, 2'b00);

        // x+w = 1030 must not wrap in 10 bits
        layer_x = {10'd320, 10'd1000};
        layer_w = {10'd20, 10'd30};
        pulse_frame();
        pix_valid = 1'b1;
        row_addr  = 110;
        col_addr  = 1010;
        tick();
        chk("wrap_addr", 32'(lyr_addr[11:0]), 310);
        pix_valid = 1'b0;
        tick();
        chk("wrap_hit", 32'(hit_mask), 32'(2'b01));
        run_pix("wrap_nohit", 110, 5, 2'b00);

        // ---- reset mid-stream ----
        set_default_layers();
        pulse_frame();
        pix_valid = 1'b1;
        row_addr  = 110;
        col_addr  = 310;
        tick();
        tick();
        chk("pre_rst_valid", 32'(rgb_valid), 1);
        clrn = 1'b0;
        #1;
        chk("mid_rst_rgb_out",   32'(rgb_out),   0);
        chk("mid_rst_rgb_valid", 32'(rgb_valid), 0);
        chk("mid_rst_hit_mask",  32'(hit_mask),  0);
        chk("mid_rst_lyr_addr",  32'(lyr_addr),  0);
        chk("mid_rst_anim_cel",  32'(anim_cel),  0);
        chk("mid_rst_collision", 32'(collision), 0);
        @(negedge vga_clk);
        clrn = 1'b1;
        tick();
        chk("post_rst_lat1_valid", 32'(rgb_valid), 0);
        tick();
        chk("post_rst_lat2_valid", 32'(rgb_valid), 1);
        chk("post_rst_rgb_bg",     32'(rgb_out),   32'h333);
        chk("post_rst_mask",       32'(hit_mask),  0);
        pix_valid = 1'b0;

        // ---- animation ----
        set_default_layers();
        anim_hold = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            pulse_frame();
            chk($sformatf("anim_pulse%0d", k), 32'(anim_cel), 32'((k / 2) % 3));
        end
        anim_hold = 1'b1;
        layer_en  = 2'b00;
        pulse_frame();
        chk("anim_hold_a", 32'(anim_cel), 0);
        pulse_frame();
        chk("anim_hold_b", 32'(anim_cel), 0);
        run_pix("hold_shadow_loaded", 110, 310, 2'b00);
        anim_hold = 1'b0;
        layer_en  = 2'b11;
        pulse_frame();
        chk("anim_resume_a", 32'(anim_cel), 0);
        pulse_frame();
        chk("anim_resume_b", 32'(anim_cel), 1);

        // ---- collision ----
        run_pix("coll_px", 108, 325, 2'b11);
        tick();
        pulse_frame();
        chk("coll_set", 32'(collision), 32'(COLL_EXP));
        pulse_frame();
        chk("coll_clear", 32'(collision), 0);
        // overlap reaches S2 on the same cycle as frame_start
        run_pix("coll_edge_px", 108, 325, 2'b11);
        pulse_frame();
        chk("coll_edge_a", 32'(collision), 0);
        pulse_frame();
        chk("coll_edge_b", 32'(collision), 32'(COLL_EXP));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised pixel compositor between the VGA timing controller and the sprite/background ROMs. For each pixel coordinate it performs per-layer hit tests, generates ROM addresses, and resolves opacity and priority across `NUM_LAYERS` sprite layers over a background colour. Layer geometry is double-buffered at frame boundaries, and sprite animation is sequenced in hardware. It replaces the hand-written bird/land/pipe priority chain in the display top level.

## Interface
- `NUM_LAYERS`, 4: sprite layer count. Layer 0 has the highest priority.
- `COLOR_W`, 12: RGB width (4:4:4).
- `X_W`, 10: column coordinate width.
- `Y_W`, 9: row coordinate width.
- `ADDR_W`, 12: per-layer ROM address width.
- `ANIM_FRAMES`, 3: animation cels per sprite (≥1).
- `ANIM_PERIOD`, 8: video frames per animation step (≥1).
- `vga_clk`  in  1  pixel clock. All logic is on its rising edge.
- `clrn`  in  1  asynchronous active-low reset.
- `pix_valid`  in  1  coordinate is in the active area.
- `row_addr`  in  Y_W  current row.
- `col_addr`  in  X_W  current column.
- `frame_start`  in  1  one-cycle pulse, issued during blanking and before the first active pixel.
- `anim_hold`  in  1  freeze the animation counter.
- `layer_en`  in  NUM_LAYERS  per-layer enable.
- `layer_x`, `layer_w`  in  NUM_LAYERS*X_W  top-left column and width.
- `layer_y`, `layer_h`  in  NUM_LAYERS*Y_W  top-left row and height.
- `lyr_addr`  out  NUM_LAYERS*ADDR_W  ROM address, registered.
- `lyr_data`  in  NUM_LAYERS*(4+COLOR_W)  {alpha, rgb} from async-read ROMs. Valid in the same cycle as `lyr_addr`.
- `bg_rgb`  in  COLOR_W  background colour aligned with `lyr_data`.
- `anim_cel`  out  $clog2(ANIM_FRAMES)  current cel index.
- `rgb_out`  out  COLOR_W  composited colour.
- `rgb_valid`  out  1  `rgb_out` is valid.
- `hit_mask`  out  NUM_LAYERS  opaque-hit bits, aligned with `rgb_out`.
- `collision`  out  1  layer 0 overlapped another opaque layer in the previous frame.

## Operation
- **Shadow registers.** On `frame_start`, the block copies `layer_en`, `layer_x`, `layer_y`, `layer_w`, `layer_h` into shadow registers. Every other cycle it ignores those inputs, so the image never tears. The reset value of every shadow register is 0, which means all layers are disabled.
- **Hit test (S1, registered).** Layer i hits when all of the following hold:
  - it is enabled;
  - `x ≤ col < x+w` and `y ≤ row < y+h`;
  - the compares are done at X_W+1 / Y_W+1 bits, so `x+w` never wraps.
  - A layer with `w=0` or `h=0` never hits.
- **Address generation (S1).** `lyr_addr_i = (row−y)*w + (col−x)` truncated to ADDR_W. When there is no hit, the address is 0.
- **Opacity.** A layer pixel is opaque only when `alpha == 4'hF`. Any other alpha value is transparent.
- **Compose (S2, registered).** `rgb_out` takes the rgb of the lowest-index opaque hit. If there is no opaque hit, it takes `bg_rgb`. `hit_mask` holds the opaque hits.
  - When S1 was not valid, `rgb_out` is 0 and `hit_mask` is 0.
- **Animation.**
  - `frame_cnt` counts `frame_start` pulses modulo ANIM_PERIOD.
  - On wrap, `anim_cel` advances modulo ANIM_FRAMES.
  - While `anim_hold` is high, both counters hold.
- **Collision.**
  - `coll_acc` sets on any S2 pixel where `hit_mask[0]` is set and any other bit is set.
  - On `frame_start`, `collision <= coll_acc` and `coll_acc` clears.
  - A hit in that same cycle loads `coll_acc` with 1, so the hit is not lost.

## Timing
- Latency is 2 cycles from `pix_valid`/`row_addr`/`col_addr` to `rgb_out`/`rgb_valid`/`hit_mask`. Throughput is 1 pixel per cycle with no stalls.
- `lyr_addr` appears 1 cycle after the coordinate. The ROMs are combinational, and `bg_rgb` must be presented in that same S1 cycle.
- A pixel presented in the same cycle as `frame_start` uses the old shadow values.
- Reset values: all outputs are 0, both pipeline valid bits are 0, and `anim_cel`, `frame_cnt`, `coll_acc`, `collision` are all 0.
- Reset asserted mid-frame: the pipeline flushes immediately. After release, the first `rgb_valid` comes 2 cycles after the first `pix_valid`.
- Simultaneous `frame_start` and `anim_hold`: the shadow registers load and the counters hold.

## Configuration
- `LAYER_COMPOSITOR_COLLISION_EN` defined: the collision accumulator and the `collision` output are implemented as described above.
- Not defined: `collision` is tied to 0 and no accumulator logic is synthesised. `hit_mask` is unaffected.

## Structure
- Package `compositor_pkg` holds:
  - the `pixel_t` struct {alpha[3:0], rgb[COLOR_W-1:0]};
  - the constant `ALPHA_OPAQUE = 4'hF`;
  - the default width constants.
- Sub-module `layer_hit`: one layer's shadow registers, range compare, and address multiply-add with registered outputs. It is instantiated NUM_LAYERS times via generate.
- The top level contains the priority encoder, animation counters, and collision logic.

## Test plan
All scenarios use `NUM_LAYERS=2` except where noted.
- **Single opaque hit.** Layer 0 at (300,100), 34×24, enabled; pixel (310,110); `lyr_data0 = 16'hF_ABC`. Expect `lyr_addr0 = 350` after 1 cycle, then `rgb_out = 12'hABC` and `hit_mask = 2'b01` after 2 cycles.
- **Transparency and priority.** Both layers overlap the pixel; `lyr_data0 = 16'h0_111`, `lyr_data1 = 16'hF_222`, `bg_rgb = 12'h333`. Expect `rgb_out = 12'h222`. With layer 1 alpha set to `4'hE`, expect `rgb_out = 12'h333`.
- **Shadow timing.** Change `layer_x0` mid-frame. Expect the hit region to be unchanged until after the next `frame_start`. Also set `layer_w0 = 0` and expect no hit anywhere.
- **Animation.** ANIM_PERIOD=2, ANIM_FRAMES=3; apply 6 `frame_start` pulses. Expect `anim_cel` to step 0→1→2→0 on pulses 2, 4, 6. With `anim_hold` high, expect no change.
- **Collision (macro defined).** One overlapping opaque pixel in frame N. Expect `collision = 1` after the next `frame_start`, and `collision = 0` after a following frame with no overlap. With the macro undefined, expect `collision` to stay 0.
- **Reset mid-stream.** Drop `clrn` for 1 cycle while `pix_valid` is high. Expect all outputs to read 0 immediately and `rgb_valid` to return 2 cycles after the first post-reset valid pixel.
